// File: rtl/dcsk_tx_sequencer_if.sv
// Bundles the DCSK TX sequencer's word, chaos, delay-register and chip-output signals.
// master = sequencer side, slave = surrounding datapath.
interface dcsk_tx_sequencer_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  Enable;
   logic [4:0]            Spread_Factor;
   logic [DATA_WIDTH-1:0] Data_In;
   logic                  Data_Valid;
   logic                  Data_Ready;
   logic                  Chaos_Chip;
   logic                  Chaos_Req;
   logic [3:0]            Del_Reg_Addr;
   logic                  Del_Reg_Load;
   logic                  Del_Reg_Re;
   logic                  Del_Reg_Data;
   logic                  Chip_Out;
   logic                  Chip_Valid;
   logic                  Chip_Ready;
   logic                  Frame_Start;
   logic                  Word_Done;
   logic                  Busy;

   modport master (
      input  Enable, Spread_Factor, Data_In, Data_Valid, Chaos_Chip, Del_Reg_Data, Chip_Ready,
      output Data_Ready, Chaos_Req, Del_Reg_Addr, Del_Reg_Load, Del_Reg_Re,
             Chip_Out, Chip_Valid, Frame_Start, Word_Done, Busy
   );

   modport slave (
      output Enable, Spread_Factor, Data_In, Data_Valid, Chaos_Chip, Del_Reg_Data, Chip_Ready,
      input  Data_Ready, Chaos_Req, Del_Reg_Addr, Del_Reg_Load, Del_Reg_Re,
             Chip_Out, Chip_Valid, Frame_Start, Word_Done, Busy
   );
endinterface

// File: rtl/dcsk_tx_sequencer.sv
// DCSK TX sequencer: serializes a word LSB first as reference/information chip halves.
// First chip one cycle after accept; Chip_Ready low freezes chip, address and counters.
module dcsk_tx_sequencer #(
   parameter int DATA_WIDTH = 32
) (
   input  logic           Clk,
   input  logic           N_Rst,
   dcsk_tx_sequencer_if.master bus
);
   localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, REF, INFO} state_t;

   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] word_q, word_d;
   logic [4:0]            sf_q, sf_d;
   logic [BW-1:0]         bit_idx_q, bit_idx_d;
   logic [3:0]            chip_cnt_q, chip_cnt_d;

   logic [4:0] sf_sat;
   logic       chip_hs;
   logic       last_chip;
   logic       last_bit;

   // Degenerate spreading factors are clamped so a half always has 2..16 chips.
   always_comb begin
      sf_sat = bus.Spread_Factor;
      if (bus.Spread_Factor < 5'd2) begin
         sf_sat = 5'd2;
      end else if (bus.Spread_Factor > 5'd16) begin
         sf_sat = 5'd16;
      end
   end

   // Enable low suppresses the handshake so an aborted chip has no side effects.
   assign chip_hs   = bus.Chip_Ready && bus.Enable;
   assign last_chip = ({1'b0, chip_cnt_q} == (sf_q - 5'd1));
   assign last_bit  = (bit_idx_q == BW'(DATA_WIDTH - 1));

   always_comb begin
      state_d    = state_q;
      word_d     = word_q;
      sf_d       = sf_q;
      bit_idx_d  = bit_idx_q;
      chip_cnt_d = chip_cnt_q;

      bus.Data_Ready   = 1'b0;
      bus.Chaos_Req    = 1'b0;
      bus.Del_Reg_Addr = 4'd0;
      bus.Del_Reg_Load = 1'b0;
      bus.Del_Reg_Re   = 1'b0;
      bus.Chip_Out     = 1'b0;
      bus.Chip_Valid   = 1'b0;
      bus.Word_Done    = 1'b0;
      bus.Busy         = (state_q != IDLE);
      bus.Frame_Start  = (state_q == REF) && (bit_idx_q == '0) && (chip_cnt_q == 4'd0);

      case (state_q)
         IDLE: begin
            bus.Data_Ready = bus.Enable && N_Rst;
            if (bus.Data_Valid && bus.Enable && N_Rst) begin
               word_d     = bus.Data_In;
               sf_d       = sf_sat;
               bit_idx_d  = '0;
               chip_cnt_d = 4'd0;
               state_d    = REF;
            end
         end
         REF: begin
            bus.Chip_Valid   = 1'b1;
            bus.Chip_Out     = bus.Chaos_Chip;
            bus.Del_Reg_Addr = chip_cnt_q;
            bus.Chaos_Req    = chip_hs;
            bus.Del_Reg_Load = chip_hs;
            if (!bus.Enable) begin
               state_d    = IDLE;
               chip_cnt_d = 4'd0;
               bit_idx_d  = '0;
            end else if (bus.Chip_Ready) begin
               if (last_chip) begin
                  chip_cnt_d = 4'd0;
                  state_d    = INFO;
               end else begin
                  chip_cnt_d = chip_cnt_q + 4'd1;
               end
            end
         end
         INFO: begin
            bus.Chip_Valid   = 1'b1;
            bus.Del_Reg_Re   = 1'b1;
            bus.Del_Reg_Addr = chip_cnt_q;
            bus.Chip_Out     = bus.Del_Reg_Data ~^ word_q[bit_idx_q];
            if (!bus.Enable) begin
               state_d    = IDLE;
               chip_cnt_d = 4'd0;
               bit_idx_d  = '0;
            end else if (bus.Chip_Ready) begin
               if (last_chip) begin
                  chip_cnt_d = 4'd0;
                  if (last_bit) begin
                     bus.Word_Done = 1'b1;
                     state_d       = IDLE;
                  end else begin
                     bit_idx_d = bit_idx_q + BW'(1);
                     state_d   = REF;
                  end
               end else begin
                  chip_cnt_d = chip_cnt_q + 4'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge N_Rst) begin
      if (!N_Rst) begin
         state_q    <= IDLE;
         word_q     <= '0;
         sf_q       <= 5'd2;
         bit_idx_q  <= '0;
         chip_cnt_q <= 4'd0;
      end else begin
         state_q    <= state_d;
         word_q     <= word_d;
         sf_q       <= sf_d;
         bit_idx_q  <= bit_idx_d;
         chip_cnt_q <= chip_cnt_d;
      end
   end
endmodule

// File: tb/tb_dcsk_tx_sequencer.sv
// Bench for dcsk_tx_sequencer: random words/chaos against a chip-stream reference model,
// plus directed backpressure, saturation, abort, reset and back-to-back scenarios.
module tb_dcsk_tx_sequencer;
   localparam int DW = 4;

   logic Clk = 1'b0;
   logic N_Rst;
   always #5 Clk = ~Clk;

   dcsk_tx_sequencer_if #(.DATA_WIDTH(DW)) bus ();

   dcsk_tx_sequencer #(.DATA_WIDTH(DW)) dut (
      .Clk   (Clk),
      .N_Rst (N_Rst),
      .bus   (bus)
   );

   int total = 0;
   int bad   = 0;

   // Chaos generator: presents chaos_mem[ptr], advances on Chaos_Req.
   logic chaos_mem [0:4095];
   int   chaos_ptr = 0;
   // Shared delay register: write on load, combinational read.
   logic dly_mem [0:15];
   logic [31:0] last_stream;

   assign bus.Chaos_Chip   = chaos_mem[chaos_ptr % 4096];
   assign bus.Del_Reg_Data = dly_mem[bus.Del_Reg_Addr];

   always @(posedge Clk) begin
      if (bus.Chaos_Req) chaos_ptr <= chaos_ptr + 1;
      if (bus.Del_Reg_Load) dly_mem[bus.Del_Reg_Addr] <= bus.Chaos_Chip;
   end

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] all_outs();
      return {22'd0, bus.Data_Ready, bus.Chaos_Req, bus.Del_Reg_Load, bus.Del_Reg_Re,
              bus.Chip_Out, bus.Chip_Valid, bus.Frame_Start, bus.Word_Done, bus.Busy,
              |bus.Del_Reg_Addr};
   endfunction

   // Sends one word, called in the second half of a cycle. Stall indices, abort and
   // reset points are chip indices (-1 = none). hold keeps Data_Valid high afterwards.
   task automatic run_word(input logic [DW-1:0] w, input logic [4:0] sf_in, input bit pat,
                           input int st0, input int st1, input int st2,
                           input int abort_at, input int rst_at, input bit hold);
      int sf, nchips, p0, bit_i, half_k, k, peak;
      bit is_ref;
      logic exp_c;
      logic [3:0] pv;
      logic [31:0] stream;
      pv = 4'b1101;
      sf = (sf_in < 5'd2) ? 2 : (sf_in > 5'd16) ? 16 : int'(sf_in);
      nchips = 2 * sf * DW;
      p0 = chaos_ptr;
      for (int i = 0; i < sf * DW; i++)
         chaos_mem[(p0 + i) % 4096] = pat ? pv[(i % sf) % 4] : 1'($urandom);

      bus.Data_In = w; bus.Spread_Factor = sf_in; bus.Data_Valid = 1'b1; bus.Chip_Ready = 1'b1;
      #1;
      chk("accept_rdy", 32'(bus.Data_Ready), 32'd1);
      chk("accept_busy", 32'(bus.Busy), 32'd0);
      @(negedge Clk);
      bus.Data_Valid    = hold;
      bus.Data_In       = DW'($urandom);
      bus.Spread_Factor = (sf == 7) ? 5'd9 : 5'd7;
      peak = 0;
      stream = '0;

      for (int idx = 0; idx < nchips; idx++) begin
         bit_i  = idx / (2 * sf);
         half_k = idx % (2 * sf);
         is_ref = (half_k < sf);
         k      = half_k % sf;
         exp_c  = chaos_mem[(p0 + bit_i * sf + k) % 4096];
         if (!is_ref && !w[bit_i]) exp_c = ~exp_c;

         if (idx == rst_at) begin
            #1 N_Rst = 1'b0;
            #1 chk("rst_outs_zero", all_outs(), 32'd0);
            @(negedge Clk);
            N_Rst = 1'b1;
            #1;
            chk("rst_release_rdy", 32'(bus.Data_Ready), 32'd1);
            chk("rst_release_busy", 32'(bus.Busy), 32'd0);
            return;
         end
         if (idx == abort_at) begin
            bus.Enable = 1'b0;
            #1;
            chk("abort_cycle_side", {29'd0, bus.Chaos_Req, bus.Del_Reg_Load, bus.Word_Done}, 32'd0);
            chk("abort_cycle_rdy", 32'(bus.Data_Ready), 32'd0);
            @(negedge Clk);
            #1;
            chk("abort_idle_busy", 32'(bus.Busy), 32'd0);
            chk("abort_idle_vld", 32'(bus.Chip_Valid), 32'd0);
            chk("abort_idle_done", 32'(bus.Word_Done), 32'd0);
            bus.Data_Valid = 1'b1;
            for (int r = 0; r < 2; r++) begin
               @(negedge Clk);
               #1;
               chk("abort_no_accept_rdy", 32'(bus.Data_Ready), 32'd0);
               chk("abort_no_accept_busy", 32'(bus.Busy), 32'd0);
            end
            @(negedge Clk);
            bus.Data_Valid = 1'b0;
            bus.Enable     = 1'b1;
            return;
         end

         if (idx == st0 || idx == st1 || idx == st2) begin
            for (int s = 0; s < 3; s++) begin
               bus.Chip_Ready = 1'b0;
               #1;
               chk("stall_chip", 32'(bus.Chip_Out), 32'(exp_c));
               chk("stall_addr", 32'(bus.Del_Reg_Addr), 32'(k));
               chk("stall_side", {30'd0, bus.Chaos_Req, bus.Del_Reg_Load}, 32'd0);
               chk("stall_vld", 32'(bus.Chip_Valid), 32'd1);
               @(negedge Clk);
            end
         end

         bus.Chip_Ready = 1'b1;
         #1;
         chk("chip_out", 32'(bus.Chip_Out), 32'(exp_c));
         chk("chip_vld", 32'(bus.Chip_Valid), 32'd1);
         chk("chip_addr", 32'(bus.Del_Reg_Addr), 32'(k));
         chk("frame_start", 32'(bus.Frame_Start), 32'(idx == 0));
         chk("word_done", 32'(bus.Word_Done), 32'(idx == nchips - 1));
         chk("chaos_req", 32'(bus.Chaos_Req), 32'(is_ref));
         chk("dly_load", 32'(bus.Del_Reg_Load), 32'(is_ref));
         chk("dly_re", 32'(bus.Del_Reg_Re), 32'(!is_ref));
         chk("busy_rdy", 32'(bus.Data_Ready), 32'd0);
         if (int'(bus.Del_Reg_Addr) > peak) peak = int'(bus.Del_Reg_Addr);
         stream = {stream[30:0], bus.Chip_Out};
         @(negedge Clk);
      end

      #1;
      chk("end_rdy", 32'(bus.Data_Ready), 32'd1);
      chk("end_vld", 32'(bus.Chip_Valid), 32'd0);
      chk("end_busy", 32'(bus.Busy), 32'd0);
      chk("chaos_used", 32'(chaos_ptr - p0), 32'(sf * DW));
      chk("addr_peak", 32'(peak), 32'(sf - 1));
      last_stream = stream;
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) chaos_mem[i] = 1'b0;
      N_Rst = 1'b0;
      bus.Enable = 1'b1; bus.Data_Valid = 1'b0; bus.Data_In = '0;
      bus.Spread_Factor = 5'd0; bus.Chip_Ready = 1'b0;
      repeat (2) @(negedge Clk);
      #1 chk("reset_outs_zero", all_outs(), 32'd0);
      @(negedge Clk);
      N_Rst = 1'b1;
      #1 chk("post_reset_rdy", 32'(bus.Data_Ready), 32'd1);
      bus.Enable = 1'b0;
      #1 chk("rdy_follows_enable", 32'(bus.Data_Ready), 32'd0);
      bus.Enable = 1'b1;

      // Basic word and the same word under backpressure.
      run_word(4'b0101, 5'd4, 1'b1, -1, -1, -1, -1, -1, 1'b0);
      chk("basic_stream", last_stream, 32'hBBB4_BBB4);
      run_word(4'b0101, 5'd4, 1'b1, 3, 7, 30, -1, -1, 1'b0);
      chk("stall_stream", last_stream, 32'hBBB4_BBB4);

      // Spreading-factor saturation.
      run_word(DW'($urandom), 5'd1, 1'b0, -1, -1, -1, -1, -1, 1'b0);
      run_word(DW'($urandom), 5'd20, 1'b0, -1, -1, -1, -1, -1, 1'b0);

      // Abort during INFO of bit 2, then a clean word.
      run_word(DW'($urandom), 5'd4, 1'b0, -1, -1, -1, 2 * 8 + 4 + 1, -1, 1'b0);
      run_word(DW'($urandom), 5'd4, 1'b0, -1, -1, -1, -1, -1, 1'b0);

      // Reset mid-REF, then a clean word.
      run_word(DW'($urandom), 5'd6, 1'b0, -1, -1, -1, -1, 2, 1'b0);
      run_word(DW'($urandom), 5'd6, 1'b0, -1, -1, -1, -1, -1, 1'b0);

      // Back-to-back words with Data_Valid held.
      run_word(DW'($urandom), 5'd5, 1'b0, -1, -1, -1, -1, -1, 1'b1);
      run_word(DW'($urandom), 5'd3, 1'b0, -1, -1, -1, -1, -1, 1'b0);

      // Random words, factors and stall points.
      for (int n = 0; n < 6; n++)
         run_word(DW'($urandom), 5'($urandom_range(0, 31)), 1'b0,
                  int'($urandom_range(0, 15)), int'($urandom_range(16, 40)), -1, -1, -1, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/dcsk_tx_sequencer.md
# dcsk_tx_sequencer

DCSK transmit-side sequencer. Accepts a parallel data word over a valid/ready handshake and serializes it LSB first. For each bit it streams one reference half (Spread_Factor chips from the chaos generator, written into the variable-delay register) and one information half (the stored chips replayed, inverted when the bit is 0). It sits between the TX data source, the chaos generator, the shared variable-delay register and the chip-level output stage, and mirrors the receiver demodulator's chip/bit framing.

## Interface
- DATA_WIDTH, 32, bits per word (2..32).
- Clk  in  1  clock, all logic on rising edge.
- N_Rst  in  1  asynchronous, active-low reset.
- Enable  in  1  sequencer enable; low aborts the current word.
- Spread_Factor  in  5  chips per half-bit; sampled at word accept.
- Data_In  in  DATA_WIDTH  word to transmit.
- Data_Valid  in  1  Data_In valid.
- Data_Ready  out  1  sequencer accepts a word this cycle.
- Chaos_Chip  in  1  current chaos chip; generator holds it until Chaos_Req.
- Chaos_Req  out  1  chaos chip consumed; generator advances.
- Del_Reg_Addr  out  4  delay-register chip address.
- Del_Reg_Load  out  1  write Chaos_Chip at Del_Reg_Addr.
- Del_Reg_Re  out  1  read enable.
- Del_Reg_Data  in  1  delay-register read data at Del_Reg_Addr (combinational read).
- Chip_Out  out  1  transmitted chip.
- Chip_Valid  out  1  Chip_Out valid.
- Chip_Ready  in  1  downstream accepts chip.
- Frame_Start  out  1  high while the first chip of a word is presented.
- Word_Done  out  1  one-cycle pulse on the handshake of the last chip of a word.
- Busy  out  1  state is not IDLE.

## Operation
- Chip handshake: a chip is sent when Chip_Valid && Chip_Ready. While Chip_Ready is low, Chip_Out, Del_Reg_Addr and all counters hold.
- SF latch: SF_eff = Spread_Factor, saturated. Values 0 and 1 become 2; values above 16 become 16. Held constant for the whole word.
- Registers: word, SF_eff, bit_idx (0..DATA_WIDTH-1), chip_cnt (4 bits, 0..SF_eff-1), state.
- IDLE: Data_Ready = Enable. On Data_Valid && Data_Ready, latch the word and SF_eff, clear bit_idx and chip_cnt, go to REF. All other outputs are 0.
- REF:
  - Outputs: Chip_Valid = 1, Chip_Out = Chaos_Chip, Del_Reg_Addr = chip_cnt, Del_Reg_Load = Chaos_Req = Chip_Ready.
  - On handshake: chip_cnt++. If chip_cnt == SF_eff-1, clear chip_cnt and go to INFO.
- INFO:
  - Outputs: Chip_Valid = 1, Del_Reg_Re = 1, Del_Reg_Addr = chip_cnt, Chip_Out = Del_Reg_Data XNOR word[bit_idx].
  - On handshake: chip_cnt++. At chip_cnt == SF_eff-1, clear chip_cnt.
    - If bit_idx == DATA_WIDTH-1: pulse Word_Done and go to IDLE.
    - Otherwise: bit_idx++ and go to REF.
- Frame_Start = (state == REF) && bit_idx == 0 && chip_cnt == 0.
- Abort: Enable low in REF or INFO forces IDLE on the next edge and clears the counters. The partial word is discarded, no Word_Done is issued, and no Chaos_Req, Del_Reg_Load or Word_Done is asserted in the abort cycle. Data_In is never accepted while Enable is low.
- Data_In and Spread_Factor changes after accept have no effect on the word in flight.

## Timing
- Reset: state = IDLE; counters and word = 0. All outputs are 0 during reset. After release, Data_Ready follows Enable.
- Accept at edge T: first REF chip is presented in cycle T+1.
- With Chip_Ready held high: one word = 2 × SF_eff × DATA_WIDTH chip cycles. Word_Done falls on the last of these cycles. IDLE (Data_Ready = 1) follows in the next cycle, so word-to-word spacing is 2·SF_eff·DATA_WIDTH + 1 cycles.
- Outputs are Mealy on Chip_Ready and Enable where stated: Chaos_Req, Del_Reg_Load, Word_Done. All other outputs decode from registered state.
- Chip_Ready low on the last chip of a half delays the state change until the handshake.

## Test plan
- **Basic word:** DATA_WIDTH=4, Spread_Factor=4, Data_In=4'b0101, chaos chips 1,0,1,1 per half, Chip_Ready=1.
  - Chip_Out stream: 1011 1011 | 1011 0100 | 1011 1011 | 1011 0100.
  - Word_Done in the 32nd chip cycle; Data_Ready high in cycle 33.
- **Backpressure:** same stimulus, Chip_Ready low for 3 cycles at chips 4, 8 and 31.
  - Identical stream.
  - Chip_Out, Del_Reg_Addr and chip_cnt stable during stalls; no Chaos_Req or Del_Reg_Load while stalled.
- **SF saturation:** Spread_Factor=1, then 20.
  - SF_eff=2 gives 4 chips per bit; SF_eff=16 gives 32 chips per bit.
  - Del_Reg_Addr peaks at 1 and 15 respectively.
- **Abort:** Enable deasserted during INFO of bit 2.
  - IDLE next cycle; Chip_Valid=0; no Word_Done; Data_Ready stays 0 until Enable rises.
  - Next word starts with Frame_Start and bit 0.
- **Mid-operation reset:** N_Rst pulsed low asynchronously mid-REF.
  - All outputs 0 immediately; IDLE after release.
  - Spread_Factor changed mid-word has no effect on chip count.
- **Back-to-back:** Data_Valid held high with two words.
  - Second accept exactly 1 cycle after first Word_Done.
  - Frame_Start asserted on the first chip of each word.
